// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle between the byte FIFO and its UART transmitter.
// The transmitter is the master: it issues read requests against the empty flag.
interface fifo_uart_tx_if;
  logic       fifo_emp;
  logic       fifo_rreq;
  logic [7:0] fifo_rdata;

  modport master (input fifo_emp, input fifo_rdata, output fifo_rreq);
  modport slave  (output fifo_emp, output fifo_rdata, input fifo_rreq);
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains the byte FIFO.
// It sends start, 8 data bits LSB first, optional even parity and 1 or 2 stop bits.
//
//   state | meaning
//   IDLE  | line high, waiting for enable and a non-empty FIFO
//   POP   | one-cycle FIFO read request
//   LOAD  | FIFO data valid; capture it and drive the start bit
//   START | start bit (low)
//   DATA  | data bits D0..D7
//   PAR   | even-parity bit
//   STOP  | stop bit(s) high; decides between the next pop and IDLE
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  fifo_uart_tx_if.master fif,
  output logic           tx,
  output logic           busy,
  output logic [15:0]    frame_cnt
);

  localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);
  localparam logic        HAS_PAR     = (PARITY_EN != 0);
  localparam logic        LAST_STOP   = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic        stop_q, stop_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        par_q, par_d;
  logic        tx_q, tx_d;
  logic        rreq_q, rreq_d;
  logic        busy_q, busy_d;
  logic [15:0] cnt_q, cnt_d;
  logic        bit_end;
  logic        pop_ok;

  assign bit_end = (baud_q == 16'd0);
  assign pop_ok  = enable & ~fif.fifo_emp;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      rreq_q  <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      rreq_q  <= rreq_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are registered from the next-state values, so each one lines up with its state.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    tx_d    = tx_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (pop_ok) state_d = POP;
      end
      POP: state_d = LOAD;
      LOAD: begin
        shreg_d = fif.fifo_rdata;
        par_d   = ^fif.fifo_rdata;
        tx_d    = 1'b0;
        baud_d  = BAUD_RELOAD;
        state_d = START;
      end
      START: begin
        if (bit_end) begin
          baud_d  = BAUD_RELOAD;
          bit_d   = 3'd0;
          tx_d    = shreg_q[0];
          shreg_d = {1'b0, shreg_q[7:1]};
          state_d = DATA;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d = BAUD_RELOAD;
          if (bit_q == 3'd7) begin
            if (HAS_PAR) begin
              tx_d    = par_q;
              state_d = PAR;
            end else begin
              tx_d    = 1'b1;
              stop_d  = 1'b0;
              state_d = STOP;
            end
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shreg_q[0];
            shreg_d = {1'b0, shreg_q[7:1]};
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      PAR: begin
        if (bit_end) begin
          baud_d  = BAUD_RELOAD;
          tx_d    = 1'b1;
          stop_d  = 1'b0;
          state_d = STOP;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop_q == LAST_STOP) begin
            cnt_d   = cnt_q + 16'd1;
            tx_d    = 1'b1;
            state_d = pop_ok ? POP : IDLE;
          end else begin
            stop_d = 1'b1;
            baud_d = BAUD_RELOAD;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase

    rreq_d = (state_d == POP);
    busy_d = (state_d != IDLE);
  end

  assign fif.fifo_rreq = rreq_q;
  assign tx            = tx_q;
  assign busy          = busy_q;
  assign frame_cnt     = cnt_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench: DUT a is 8N1 and DUT b is 8E2, both at 4 clocks per bit, each fed by a small FIFO model.
// The rreq-to-rreq spacing of back-to-back frames is the frame length plus the POP and LOAD cycles.
module tb_fifo_uart_tx;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en_a = 1'b0;
  logic        en_b = 1'b0;
  logic        a_tx, a_busy, b_tx, b_busy;
  logic [15:0] a_fc, b_fc;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int fall_cyc = 0;

  fifo_uart_tx_if a_if ();
  fifo_uart_tx_if b_if ();

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(1)) u_a (
    .clk(clk), .reset(reset), .enable(en_a), .fif(a_if),
    .tx(a_tx), .busy(a_busy), .frame_cnt(a_fc));

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(2)) u_b (
    .clk(clk), .reset(reset), .enable(en_b), .fif(b_if),
    .tx(b_tx), .busy(b_busy), .frame_cnt(b_fc));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO models: data appears on rdata the cycle after the request cycle.
  logic [7:0] a_mem [16];
  logic [7:0] b_mem [16];
  int a_wr = 0, a_rd = 0, a_pops = 0, a_viol = 0;
  int b_wr = 0, b_rd = 0, b_pops = 0, b_viol = 0;
  int a_pop_cyc [16];

  assign a_if.fifo_emp = (a_wr == a_rd);
  assign b_if.fifo_emp = (b_wr == b_rd);

  always @(posedge clk) begin
    if (a_if.fifo_rreq) begin
      if (a_wr == a_rd) a_viol <= a_viol + 1;
      else begin
        a_if.fifo_rdata <= a_mem[a_rd[3:0]];
        a_rd <= a_rd + 1;
      end
      a_pop_cyc[a_pops[3:0]] <= cyc;
      a_pops <= a_pops + 1;
    end
    if (b_if.fifo_rreq) begin
      if (b_wr == b_rd) b_viol <= b_viol + 1;
      else begin
        b_if.fifo_rdata <= b_mem[b_rd[3:0]];
        b_rd <= b_rd + 1;
      end
      b_pops <= b_pops + 1;
    end
  end

  task automatic push_a(input logic [7:0] d);
    a_mem[a_wr[3:0]] = d;
    a_wr = a_wr + 1;
  endtask

  task automatic push_b(input logic [7:0] d);
    b_mem[b_wr[3:0]] = d;
    b_wr = b_wr + 1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic txs(input bit sb);
    return sb ? b_tx : a_tx;
  endfunction

  // Receives one frame by sampling the middle of every bit; optionally drops en_a during data bit drop_bit.
  task automatic rx(input bit sb, input bit hp, input int drop_bit,
                    output logic [7:0] d, output logic p);
    bit got = 1'b0;
    d = '0;
    p = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (txs(sb) == 1'b0) got = 1'b1;
    end
    check("rx_start_seen", 32'(got), 32'd1);
    fall_cyc = cyc;
    repeat (2) @(negedge clk);
    check("rx_start_bit", 32'(txs(sb)), 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (4) @(negedge clk);
      d[i] = txs(sb);
      if (i == drop_bit) en_a = 1'b0;
    end
    if (hp) begin
      repeat (4) @(negedge clk);
      p = txs(sb);
    end
    repeat (4) @(negedge clk);
    check("rx_stop_bit", 32'(txs(sb)), 32'd1);
  endtask

  initial begin
    logic [7:0]  d;
    logic        p;
    logic [7:0]  a5;
    bit          found;
    int          bad;
    logic [15:0] fc0;

    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_a_tx", 32'(a_tx), 32'd1);
    check("rst_a_rreq", 32'(a_if.fifo_rreq), 32'd0);
    check("rst_a_busy", 32'(a_busy), 32'd0);
    check("rst_a_fc", 32'(a_fc), 32'd0);
    check("rst_b_tx", 32'(b_tx), 32'd1);
    check("rst_b_fc", 32'(b_fc), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Test 1: single byte 0xA5
    push_a(8'hA5);
    en_a = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (a_if.fifo_rreq) found = 1'b1;
    end
    check("t1_rreq_seen", 32'(found), 32'd1);
    check("t1_busy_at_pop", 32'(a_busy), 32'd1);
    check("t1_tx_at_pop", 32'(a_tx), 32'd1);
    @(negedge clk);
    check("t1_rreq_one_cycle", 32'(a_if.fifo_rreq), 32'd0);
    check("t1_tx_at_load", 32'(a_tx), 32'd1);
    @(negedge clk);
    check("t1_tx_fall_k2", 32'(a_tx), 32'd0);
    repeat (2) @(negedge clk);
    check("t1_start_mid", 32'(a_tx), 32'd0);
    a5 = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      repeat (4) @(negedge clk);
      check($sformatf("t1_bit%0d", i), 32'(a_tx), 32'(a5[i]));
    end
    repeat (4) @(negedge clk);
    check("t1_stop", 32'(a_tx), 32'd1);
    check("t1_fc_before_end", 32'(a_fc), 32'd0);
    repeat (2) @(negedge clk);
    check("t1_fc", 32'(a_fc), 32'd1);
    check("t1_busy_idle", 32'(a_busy), 32'd0);
    check("t1_pops", 32'(a_pops), 32'd1);

    // Test 2: three queued bytes back to back
    push_a(8'h01);
    push_a(8'h02);
    push_a(8'h03);
    rx(1'b0, 1'b0, -1, d, p);
    check("t2_byte0", 32'(d), 32'h01);
    rx(1'b0, 1'b0, -1, d, p);
    check("t2_byte1", 32'(d), 32'h02);
    rx(1'b0, 1'b0, -1, d, p);
    check("t2_byte2", 32'(d), 32'h03);
    repeat (2) @(negedge clk);
    check("t2_fc", 32'(a_fc), 32'd4);
    check("t2_pops", 32'(a_pops), 32'd4);
    check("t2_gap12", 32'(a_pop_cyc[2] - a_pop_cyc[1]), 32'd42);
    check("t2_gap23", 32'(a_pop_cyc[3] - a_pop_cyc[2]), 32'd42);

    // Test 3: 8E2 frame of 0x07 on DUT b
    push_b(8'h07);
    en_b = 1'b1;
    rx(1'b1, 1'b1, -1, d, p);
    check("t3_byte", 32'(d), 32'h07);
    check("t3_parity", 32'(p), 32'd1);
    repeat (4) @(negedge clk);
    check("t3_stop2", 32'(b_tx), 32'd1);
    check("t3_fc_before_end", 32'(b_fc), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (b_fc != 16'd0) found = 1'b1;
    end
    check("t3_fc", 32'(b_fc), 32'd1);
    check("t3_frame_len", 32'(cyc - fall_cyc), 32'd48);
    check("t3_busy_idle", 32'(b_busy), 32'd0);
    check("t3_pops", 32'(b_pops), 32'd1);

    // Test 4: enable dropped during D3 of 0x55 with 0x66 still queued
    push_a(8'h55);
    push_a(8'h66);
    rx(1'b0, 1'b0, 3, d, p);
    check("t4_byte", 32'(d), 32'h55);
    repeat (2) @(negedge clk);
    check("t4_fc", 32'(a_fc), 32'd5);
    repeat (60) @(negedge clk);
    check("t4_no_pop", 32'(a_pops), 32'd5);
    check("t4_fifo_holds", 32'(a_if.fifo_emp), 32'd0);
    check("t4_busy", 32'(a_busy), 32'd0);
    check("t4_tx", 32'(a_tx), 32'd1);

    // Test 5: reset during D0 of 0x66, then a clean 0x3C
    en_a = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (a_tx == 1'b0) found = 1'b1;
    end
    check("t5_fall_seen", 32'(found), 32'd1);
    repeat (6) @(negedge clk);
    check("t5_d0", 32'(a_tx), 32'd0);
    check("t5_busy_data", 32'(a_busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("t5_rst_tx", 32'(a_tx), 32'd1);
    check("t5_rst_busy", 32'(a_busy), 32'd0);
    check("t5_rst_rreq", 32'(a_if.fifo_rreq), 32'd0);
    check("t5_rst_fc", 32'(a_fc), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    push_a(8'h3C);
    rx(1'b0, 1'b0, -1, d, p);
    check("t5_byte_after", 32'(d), 32'h3C);
    repeat (2) @(negedge clk);
    check("t5_fc_after", 32'(a_fc), 32'd1);
    check("t5_pops", 32'(a_pops), 32'd7);

    // Test 6: enabled with an empty FIFO
    fc0 = a_fc;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (a_tx !== 1'b1 || a_if.fifo_rreq !== 1'b0 || a_busy !== 1'b0) bad++;
    end
    check("t6_quiet_cycles", 32'(bad), 32'd0);
    check("t6_pops", 32'(a_pops), 32'd7);
    check("t6_fc", 32'(a_fc), 32'(fc0));
    check("rreq_on_empty_a", 32'(a_viol), 32'd0);
    check("rreq_on_empty_b", 32'(b_viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
